// File: rtl/axis_stream_fifo_if.sv
// rtl/axis_stream_fifo_if.sv - write-side and stream-side signals of axis_stream_fifo
// master: the FIFO, which sources the stream; slave: the surrounding logic.
interface axis_stream_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [DATA_W-1:0] din;
  logic              push;
  logic              op_en;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    input  din, push, op_en, tready,
    output tdata, tvalid, tlast, level, full, empty, err
  );

  modport slave (
    output din, push, op_en, tready,
    input  tdata, tvalid, tlast, level, full, empty, err
  );
endinterface

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - circular buffer feeding a registered stream output stage
// Optional sticky overflow/underrun flag: define STREAM_FIFO_STICKY_ERR_EN.
module axis_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  axis_stream_fifo_if.master s
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   level;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              full;
  logic              wr_fire;
  logic              rd_fire;

  assign full    = (level == (ADDR_W+1)'(DEPTH));
  assign wr_fire = s.push && !full;
  assign rd_fire = s.op_en && (level != '0) && (!tvalid || s.tready);

  // Memory has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr] <= s.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_fire) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_fire) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // tlast marks a load that takes the final stored word with nothing arriving behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (rd_fire) begin
      tdata  <= mem[rptr];
      tvalid <= 1'b1;
      tlast  <= (level == (ADDR_W+1)'(1)) && !wr_fire;
    end else if (tvalid && s.tready) begin
      tvalid <= 1'b0;
    end
  end

`ifdef STREAM_FIFO_STICKY_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((s.push && full) ||
                 (s.tready && !tvalid && s.op_en && (level == '0))) begin
      err_q <= 1'b1;
    end
  end

  assign s.err = err_q;
`else
  assign s.err = 1'b0;
`endif

  assign s.tdata  = tdata;
  assign s.tvalid = tvalid;
  assign s.tlast  = tlast;
  assign s.level  = level;
  assign s.full   = full;
  assign s.empty  = (level == '0) && !tvalid;
endmodule

// File: doc/axis_stream_fifo.md
AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of din and tdata in bits.
REQ-002 Parameter DEPTH, default 16, buffer depth in words; power of two, >= 2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), pointer width; never overridden by the instantiator.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  DATA_W  write data.
REQ-007 push  input  1  write request.
REQ-008 op_en  input  1  output enable; permits loading of the output stage.
REQ-009 tready  input  1  downstream ready.
REQ-010 tdata  output  DATA_W  stream data, registered.
REQ-011 tvalid  output  1  stream data valid, registered.
REQ-012 tlast  output  1  last word of the current burst, registered.
REQ-013 level  output  ADDR_W+1  words held in the buffer memory, excluding the output stage.
REQ-014 full  output  1  level == DEPTH, combinational from level.
REQ-015 empty  output  1  (level == 0) && !tvalid, combinational.
REQ-016 err  output  1  sticky error flag; see Configuration.

Function
REQ-017 Buffer SHALL be circular, with wptr/rptr of ADDR_W bits wrapping DEPTH-1 -> 0 and no pointer resets other than rst_n.
REQ-018 Push accepted (wr_fire) iff push && !full, independent of op_en; din written to mem[wptr], wptr +1.
REQ-019 Push while full SHALL be dropped with no change to memory, pointers or level.
REQ-020 Output stage loads (rd_fire) iff op_en && level != 0 && (!tvalid || tready); tdata <= mem[rptr], rptr +1, tvalid <= 1.
REQ-021 tvalid SHALL clear on tvalid && tready && !rd_fire.
REQ-022 While tvalid && !tready, tdata, tvalid and tlast SHALL hold stable, including when op_en deasserts.
REQ-023 op_en low SHALL block new loads only; a word already presented SHALL remain valid until accepted.
REQ-024 tlast SHALL be set on a load iff level == 1 && !wr_fire in that cycle; otherwise cleared on the load; held otherwise.
REQ-025 Simultaneous wr_fire and rd_fire SHALL leave level unchanged; wr_fire alone adds 1, rd_fire alone subtracts 1.
REQ-026 Simultaneous wr_fire and rd_fire at level == 1 SHALL output the old word, store the new one, and leave tlast = 0.
REQ-027 A word written at edge N SHALL be loadable at edge N+1 at the earliest; no bypass of memory.
REQ-028 Throughput: one word per cycle with tready held high and a continuous supply.

Reset
REQ-029 rst_n low SHALL asynchronously force tdata=0, tvalid=0, tlast=0, level=0, wptr=0, rptr=0 and err=0, giving full=0 and empty=1.
REQ-030 Memory contents are not reset.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered and presented words.
REQ-032 First wr_fire is possible at the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro STREAM_FIFO_STICKY_ERR_EN.
- Defined: err sets on push && full (overflow) or on tready && !tvalid && op_en && level == 0 (underrun); it clears only on reset.
- Undefined: err is tied 0 and no error logic is built.

Verification
REQ-034 Write 0x01..0x10, then op_en=1 with tready=1 -> tdata 0x01..0x10 on consecutive cycles; tlast only with 0x10; then empty=1.
REQ-035 At level=16, write 0xAA -> dropped, level stays 16; with the macro, err=1; without it, err=0.
REQ-036 tready low for 3 cycles while presenting 0x05 -> tdata=0x05 and tvalid=1 stable; op_en toggling low does not clear tvalid.
REQ-037 Streaming with push and tready continuously high for 40 cycles -> level steady, pointers wrap past 15, data order preserved, tlast never set.
REQ-038 rst_n pulsed low asynchronously between edges at level=7 with tvalid=1 -> outputs take their reset values immediately, before the next edge; the next word written is the next word read.
REQ-039 DATA_W=32, DEPTH=64 instance -> REQ-034 through REQ-037 pass scaled; full=1 at level 64.
